// File: rtl/ser_pkg.sv
// Shared serial-link definitions: FSM state encoding and line levels.
// Used by both ends of the sampled single-bit link.
package ser_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    SHIFT = 2'd2,
    STOP  = 2'd3
  } ser_state_t;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_LVL = 1'b0;
  localparam logic STOP_LVL  = 1'b1;

endpackage

// File: rtl/ser_bitcnt.sv
// Data-bit counter: clear/enable up-counter, saturates at WIDTH-1, tc high there.
// Zero latency on tc; no backpressure, it only counts what the FSM enables.
module ser_bitcnt #(
  parameter int WIDTH = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int CW = $clog2(WIDTH);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !tc) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tc = (cnt == CW'(WIDTH - 1));

endmodule

// File: rtl/ser_tx.sv
// Framed parallel-to-serial transmitter: start bit, WIDTH data bits MSB first, stop bit.
// First data bit two edges after accept; LOAD only taken while READY (IDLE/STOP), else dropped.
module ser_tx
  import ser_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             CK,
  input  logic             RST,
  input  logic [WIDTH-1:0] DIN,
  input  logic             LOAD,
  output logic             READY,
  output logic             SO,
  output logic             FRAME,
  output logic             DONE
);

  ser_state_t       state, state_n;
  logic [WIDTH-1:0] sreg, sreg_n;
  logic             cnt_clr, cnt_en, cnt_tc;
  logic             so_n, ready_n, frame_n, done_n;

  ser_bitcnt #(.WIDTH(WIDTH)) u_bitcnt (
    .clk (CK),
    .rst (RST),
    .clr (cnt_clr),
    .en  (cnt_en),
    .tc  (cnt_tc)
  );

  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
      sreg  <= '0;
      SO    <= LINE_IDLE;
      READY <= 1'b1;
      FRAME <= 1'b0;
      DONE  <= 1'b0;
    end else begin
      state <= state_n;
      sreg  <= sreg_n;
      SO    <= so_n;
      READY <= ready_n;
      FRAME <= frame_n;
      DONE  <= done_n;
    end
  end

  always_comb begin
    state_n = state;
    sreg_n  = sreg;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
    case (state)
      IDLE, STOP: begin
        if (LOAD && READY) begin
          state_n = START;
          sreg_n  = DIN;
          cnt_clr = 1'b1;
        end else begin
          state_n = IDLE;
        end
      end
      START: state_n = SHIFT;
      SHIFT: begin
        sreg_n = {sreg[WIDTH-2:0], 1'b0};
        if (cnt_tc) state_n = STOP;
        else        cnt_en  = 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end

  // Outputs are registered, so they are decoded from the state being entered.
  always_comb begin
    so_n    = LINE_IDLE;
    ready_n = 1'b0;
    frame_n = 1'b0;
    done_n  = 1'b0;
    case (state_n)
      IDLE:  ready_n = 1'b1;
      START: so_n = START_LVL;
      SHIFT: begin
        so_n    = sreg_n[WIDTH-1];
        frame_n = 1'b1;
      end
      STOP: begin
        so_n    = STOP_LVL;
        done_n  = 1'b1;
        ready_n = 1'b1;
      end
      default: ready_n = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_ser_tx.sv
// Bench for ser_tx: vector tables, directed corner sequences and a frame-level random model.
module tb_ser_tx;

  localparam logic [3:0] O_IDLE  = 4'b1001;  // {SO,FRAME,DONE,READY}
  localparam logic [3:0] O_START = 4'b0000;
  localparam logic [3:0] O_STOP  = 4'b1011;

  typedef struct {
    logic       ld;
    logic [7:0] din;
    logic [3:0] exp;
  } vec_t;

  logic       CK = 1'b0;
  logic       RST = 1'b0;
  logic [7:0] DIN = '0;
  logic       LOAD = 1'b0;
  logic       READY, SO, FRAME, DONE;
  logic [1:0] din2 = '0;
  logic       load2 = 1'b0;
  logic       ready2, so2, frame2, done2;

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [3:0] exp_q[$];
  logic [3:0] cur = O_IDLE;
  logic [7:0] acc_q[$];
  logic [7:0] rx_q[$];
  logic [7:0] rx_sh = '0;
  int         rx_n = 0;

  ser_tx #(.WIDTH(8)) dut (
    .CK(CK), .RST(RST), .DIN(DIN), .LOAD(LOAD),
    .READY(READY), .SO(SO), .FRAME(FRAME), .DONE(DONE)
  );

  ser_tx #(.WIDTH(2)) dut2 (
    .CK(CK), .RST(RST), .DIN(din2), .LOAD(load2),
    .READY(ready2), .SO(so2), .FRAME(frame2), .DONE(done2)
  );

  always #5 CK = ~CK;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, required %0h", nm, act, exp);
  endtask

  function automatic vec_t mk(input logic ld, input logic [7:0] d, input logic [3:0] e);
    vec_t v;
    v.ld = ld; v.din = d; v.exp = e;
    return v;
  endfunction

  function automatic logic [3:0] dat(input logic b);
    return {b, 3'b100};
  endfunction

  // Reference model works per frame: an accepted word expands to its full output sequence.
  task automatic apply(input logic ld, input logic [7:0] d);
    LOAD = ld;
    DIN  = d;
    if (ld && cur[0]) begin
      exp_q.push_back(O_START);
      for (int k = 7; k >= 0; k--) exp_q.push_back(dat(d[k]));
      exp_q.push_back(O_STOP);
      acc_q.push_back(d);
    end
    @(posedge CK);
    cur = (exp_q.size() != 0) ? exp_q.pop_front() : O_IDLE;
    @(negedge CK);
    if (FRAME) begin
      rx_sh = {rx_sh[6:0], SO};
      rx_n++;
      if (rx_n == 8) begin
        rx_q.push_back(rx_sh);
        rx_n = 0;
      end
    end
  endtask

  task automatic tick(input logic ld, input logic [7:0] d, input string nm);
    apply(ld, d);
    check(nm, {28'd0, SO, FRAME, DONE, READY}, {28'd0, cur});
  endtask

  task automatic clear_model();
    exp_q.delete(); acc_q.delete(); rx_q.delete();
    cur = O_IDLE; rx_n = 0;
  endtask

  initial begin
    vec_t       tab[11];
    vec_t       tab2[5];
    logic [7:0] a5;
    logic [9:0] soseq;
    int         idle_seen;
    logic [7:0] w;

    // Asynchronous reset, no clock edge yet
    #2 RST = 1'b1;
    #1 check("reset_async", {28'd0, SO, FRAME, DONE, READY}, {28'd0, O_IDLE});
    @(negedge CK);
    RST = 1'b0;

    // Single frame A5 as a vector table
    a5 = 8'hA5;
    tab[0] = mk(1'b1, a5, O_START);
    for (int k = 1; k <= 8; k++) tab[k] = mk(1'b0, 8'h00, dat(a5[8-k]));
    tab[9]  = mk(1'b0, 8'h00, O_STOP);
    tab[10] = mk(1'b0, 8'h00, O_IDLE);
    clear_model();
    for (int i = 0; i < 11; i++) begin
      apply(tab[i].ld, tab[i].din);
      check($sformatf("a5_row%0d", i), {28'd0, SO, FRAME, DONE, READY}, {28'd0, tab[i].exp});
    end
    check("a5_word", {24'd0, (rx_q.size() != 0) ? rx_q.pop_front() : 8'hxx}, 32'hA5);

    // Back-to-back 3C then C3, load held during STOP
    clear_model();
    idle_seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick(i == 0 || i == 10, (i == 0) ? 8'h3C : 8'hC3, $sformatf("b2b_%0d", i));
      if ({SO, FRAME, DONE, READY} == O_IDLE) idle_seen++;
    end
    check("b2b_no_gap", idle_seen, 0);
    tick(1'b0, 8'h00, "b2b_end");
    check("b2b_nwords", rx_q.size(), 2);
    check("b2b_w0", {24'd0, (rx_q.size() != 0) ? rx_q.pop_front() : 8'hxx}, 32'h3C);
    check("b2b_w1", {24'd0, (rx_q.size() != 0) ? rx_q.pop_front() : 8'hxx}, 32'hC3);

    // LOAD while busy is dropped
    clear_model();
    for (int i = 0; i < 13; i++)
      tick(i == 0 || i == 4, (i == 0) ? 8'h00 : 8'hFF, $sformatf("busy_%0d", i));
    check("busy_idle", {28'd0, SO, FRAME, DONE, READY}, {28'd0, O_IDLE});
    check("busy_nwords", rx_q.size(), 1);
    check("busy_w0", {24'd0, (rx_q.size() != 0) ? rx_q.pop_front() : 8'hxx}, 32'h00);

    // Reset after the 4th data bit, then a clean 81 frame
    clear_model();
    for (int i = 0; i < 5; i++) tick(i == 0, 8'hF0, $sformatf("mid_%0d", i));
    check("mid_so_before", {31'd0, SO}, 32'd1);
    #2 RST = 1'b1;
    #1 check("mid_reset", {28'd0, SO, FRAME, DONE, READY}, {28'd0, O_IDLE});
    @(negedge CK);
    RST = 1'b0;
    clear_model();
    soseq = '0;
    for (int i = 0; i < 10; i++) begin
      tick(i == 0, 8'h81, $sformatf("post_%0d", i));
      soseq = {soseq[8:0], SO};
    end
    check("post_soseq", {22'd0, soseq}, {22'd0, 10'b0100000011});
    tick(1'b0, 8'h00, "post_idle");

    // WIDTH=2 instance, DIN=2'b10
    tab2[0] = mk(1'b1, 8'h02, O_START);
    tab2[1] = mk(1'b0, 8'h00, 4'b1100);
    tab2[2] = mk(1'b0, 8'h00, 4'b0100);
    tab2[3] = mk(1'b0, 8'h00, O_STOP);
    tab2[4] = mk(1'b0, 8'h00, O_IDLE);
    for (int i = 0; i < 5; i++) begin
      load2 = tab2[i].ld;
      din2  = tab2[i].din[1:0];
      @(posedge CK);
      @(negedge CK);
      check($sformatf("w2_row%0d", i), {28'd0, so2, frame2, done2, ready2}, {28'd0, tab2[i].exp});
    end
    load2 = 1'b0;

    // Random traffic against the frame-level model
    clear_model();
    for (int i = 0; i < 400; i++)
      tick($urandom_range(0, 3) == 0, 8'($urandom), $sformatf("rnd_%0d", i));
    for (int i = 0; i < 12; i++) tick(1'b0, 8'h00, $sformatf("drain_%0d", i));
    check("rnd_nwords", rx_q.size(), acc_q.size());
    for (int i = 0; i < acc_q.size() && i < rx_q.size(); i++) begin
      w = rx_q[i];
      check($sformatf("rnd_word%0d", i), {24'd0, w}, {24'd0, acc_q[i]});
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
